// File: rtl/fetch_decode_sequencer.sv
// fetch_decode_sequencer
//   Sits between the instruction memory port and the decoder. Fetches aligned
//   doublewords, splits each into two instruction words (low word first),
//   hands them to the decoder one at a time, follows branch redirects and
//   stops on an all-zero instruction word.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   start, entry_pc   begin fetching at entry_pc (only while idle)
//   mem_req_*         fetch request (valid/ready), doubleword-aligned address
//   mem_resp_*        fetch response, one per accepted request, in order
//   redirect_*        branch/jump redirect to a new PC
//   dec_*             instruction + PC to the decoder (valid/ready)
//   busy              not idle
//   halted            one-cycle pulse after a zero instruction is reached
//   instr_count       number of completed decoder handshakes
module fetch_decode_sequencer #(
   parameter int unsigned       ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] entry_pc,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [63:0]       mem_resp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              dec_valid,
   output logic [31:0]       dec_instr,
   output logic [ADDR_W-1:0] dec_pc,
   input  logic              dec_ready,
   output logic              busy,
   output logic              halted,
   output logic [31:0]       instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN,
      S_FLUSH
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              slot_q, slot_d;
   logic [63:0]       buf_q, buf_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              halted_q, halted_d;

   logic [31:0]       word;
   logic              word_zero;
   logic              hs;
   logic [ADDR_W-1:0] redir_al;
   logic [ADDR_W-1:0] entry_al;

   assign word      = slot_q ? buf_q[63:32] : buf_q[31:0];
   assign word_zero = (word == 32'h0);
   assign redir_al  = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign entry_al  = {entry_pc[ADDR_W-1:2], 2'b00};

   // every output is a function of registered state only
   assign mem_req_valid = (state_q == S_REQ);
   assign mem_req_addr  = {pc_q[ADDR_W-1:3], 3'b000};
   assign dec_valid     = (state_q == S_DRAIN) && !word_zero;
   assign dec_instr     = word;
   assign dec_pc        = pc_q;
   assign busy          = (state_q != S_IDLE);
   assign halted        = halted_q;
   assign instr_count   = cnt_q;

   assign hs = dec_valid && dec_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         slot_q   <= 1'b0;
         buf_q    <= '0;
         cnt_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         slot_q   <= slot_d;
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      slot_d   = slot_q;
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      halted_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = entry_al;
               state_d = S_REQ;
            end
         end

         S_REQ: begin
            if (redirect_valid) begin
               // an accepted old request still owes a response: flush it
               pc_d = redir_al;
               if (mem_req_ready) state_d = S_FLUSH;
            end else if (mem_req_ready) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (redirect_valid) begin
               pc_d    = redir_al;
               state_d = mem_resp_valid ? S_REQ : S_FLUSH;
            end else if (mem_resp_valid) begin
               buf_d   = mem_resp_data;
               slot_d  = pc_q[2];
               state_d = S_DRAIN;
            end
         end

         S_DRAIN: begin
            // a handshake coinciding with a redirect still counts
            if (hs) cnt_d = cnt_q + 32'd1;
            if (redirect_valid) begin
               pc_d    = redir_al;
               state_d = S_REQ;
            end else if (word_zero) begin
               state_d  = S_IDLE;
               halted_d = 1'b1;
            end else if (hs) begin
               pc_d = pc_q + ADDR_W'(4);
               if (!slot_q) slot_d  = 1'b1;
               else         state_d = S_REQ;
            end
         end

         S_FLUSH: begin
            if (redirect_valid) pc_d = redir_al;
            if (mem_resp_valid) state_d = S_REQ;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fetch_decode_sequencer.sv
// Bench for fetch_decode_sequencer: instruction memory model, a program-walk
// reference model (expected fetch addresses, decoder pairs, halt PC), a
// negedge compare process and directed scenarios with literal expectations.
module tb_fetch_decode_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [63:0] entry_pc;
   logic        mem_req_valid;
   logic [63:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [63:0] dec_pc;
   logic        dec_ready;
   logic        busy;
   logic        halted;
   logic [31:0] instr_count;

   fetch_decode_sequencer #(
      .ADDR_W  (64),
      .RESET_PC(64'h0)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .entry_pc      (entry_pc),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .dec_valid     (dec_valid),
      .dec_instr     (dec_instr),
      .dec_pc        (dec_pc),
      .dec_ready     (dec_ready),
      .busy          (busy),
      .halted        (halted),
      .instr_count   (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } dec_t;

   int unsigned n_vec;
   int unsigned n_bad;

   logic [31:0] imem [logic [63:0]];

   dec_t        exp_dec[$];
   logic [63:0] exp_fetch[$];
   logic        halt_pend;
   logic [63:0] halt_pc;
   int unsigned exp_count;
   int unsigned halt_cnt;
   logic        halted_prev;
   int unsigned outst;
   logic        chk_en;

   dec_t        hs_log[$];
   logic [63:0] fetch_log[$];

   logic        auto_ready;
   int unsigned resp_lat;
   int unsigned pend_cnt;
   logic [63:0] pend_addr;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd(input logic [63:0] a);
      return imem.exists(a) ? imem[a] : 32'h0;
   endfunction

   // Walk the program from pc: each new doubleword costs a fetch, each
   // non-zero word is one decoder handoff, the first zero word halts.
   function automatic void build(input logic [63:0] spc);
      logic [63:0] pc;
      dec_t        e;
      pc = {spc[63:2], 2'b00};
      exp_dec.delete();
      exp_fetch.delete();
      halt_pend = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (i == 0 || pc[2] == 1'b0) exp_fetch.push_back({pc[63:3], 3'b000});
         if (rd(pc) == 32'h0) begin
            halt_pend = 1'b1;
            halt_pc   = pc;
            break;
         end
         e.pc    = pc;
         e.instr = rd(pc);
         exp_dec.push_back(e);
         pc = pc + 64'd4;
      end
   endfunction

   task automatic mem_loop();
      forever begin
         @(posedge clk);
         #2;
         mem_resp_valid = 1'b0;
         if (!reset_n) begin
            pend_cnt = 0;
         end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = {rd(pend_addr + 64'd4), rd(pend_addr)};
            end
         end
         mem_req_ready = auto_ready;
         if (reset_n && mem_req_valid && mem_req_ready) begin
            pend_addr = mem_req_addr;
            pend_cnt  = resp_lat;
            fetch_log.push_back(mem_req_addr);
         end
      end
   endtask

   task automatic mon_loop();
      dec_t e;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("instr_count", 64'(instr_count), 64'(exp_count));
            if (dec_valid) begin
               chk("busy_with_dec", 64'(busy), 64'd1);
               if (exp_dec.size() == 0) begin
                  chk("dec_unexpected", 64'(dec_valid), 64'd0);
               end else begin
                  chk("dec_pc", dec_pc, exp_dec[0].pc);
                  chk("dec_instr", 64'(dec_instr), 64'(exp_dec[0].instr));
                  if (dec_ready) begin
                     e.pc    = dec_pc;
                     e.instr = dec_instr;
                     hs_log.push_back(e);
                     void'(exp_dec.pop_front());
                     exp_count++;
                  end
               end
            end
            if (mem_resp_valid && outst > 0) outst--;
            if (mem_req_valid) begin
               chk("busy_with_req", 64'(busy), 64'd1);
               if (exp_fetch.size() == 0) begin
                  chk("req_unexpected", 64'(mem_req_valid), 64'd0);
               end else begin
                  chk("mem_req_addr", mem_req_addr, exp_fetch[0]);
                  if (mem_req_ready) begin
                     chk("one_outstanding", 64'(outst), 64'd0);
                     outst++;
                     void'(exp_fetch.pop_front());
                  end
               end
            end
            if (halted) begin
               chk("halt_expected", 64'(halt_pend), 64'd1);
               chk("halt_pc", dec_pc, halt_pc);
               chk("halt_busy", 64'(busy), 64'd0);
               chk("halt_width", 64'(halted_prev), 64'd0);
               halt_pend = 1'b0;
               halt_cnt++;
            end
         end
         halted_prev = halted;
      end
   endtask

   task automatic start_at(input logic [63:0] pc);
      build(pc);
      entry_pc = pc;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic redirect_to(input logic [63:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      build(pc);
   endtask

   task automatic wait_for(input int unsigned what, input string nm);
      int unsigned n = 0;
      while (((what == 0) ? dec_valid : mem_req_valid) !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(nm, 64'(n < 100), 64'd1);
   endtask

   task automatic wait_idle(input string nm);
      int unsigned n = 0;
      while (busy !== 1'b0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(nm, 64'(n < 300), 64'd1);
      @(posedge clk);
      #1;
      chk("model_dec_drained", 64'(exp_dec.size()), 64'd0);
      chk("model_fetch_drained", 64'(exp_fetch.size()), 64'd0);
      chk("model_halt_seen", 64'(halt_pend), 64'd0);
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_req_valid"}, 64'(mem_req_valid), 64'd0);
      chk({nm, "_req_addr"}, mem_req_addr, 64'h0);
      chk({nm, "_dec_valid"}, 64'(dec_valid), 64'd0);
      chk({nm, "_dec_instr"}, 64'(dec_instr), 64'd0);
      chk({nm, "_dec_pc"}, dec_pc, 64'h0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_halted"}, 64'(halted), 64'd0);
      chk({nm, "_count"}, 64'(instr_count), 64'd0);
   endtask

   initial begin
      int unsigned f0;
      int unsigned h0;
      n_vec = 0; n_bad = 0;
      reset_n = 1'b0; start = 1'b0; entry_pc = '0;
      redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      auto_ready = 1'b1; resp_lat = 2; pend_cnt = 0; pend_addr = '0;
      exp_count = 0; halt_cnt = 0; halted_prev = 1'b0; outst = 0;
      halt_pend = 1'b0; halt_pc = '0; chk_en = 1'b0;

      imem[64'h1000] = 32'h00100073;
      imem[64'h1004] = 32'h00500093;
      imem[64'h2000] = 32'hAAAA0001;
      imem[64'h2004] = 32'h00000013;
      imem[64'h2008] = 32'h11111111;
      imem[64'h3000] = 32'h00000093;
      imem[64'h3004] = 32'h12345678;
      imem[64'h4000] = 32'h00400013;

      fork
         mem_loop();
         mon_loop();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      chk_en  = 1'b1;
      @(posedge clk);
      #1;

      // sequential fetch
      f0 = fetch_log.size(); h0 = hs_log.size();
      start_at(64'h1000);
      chk("seq_first_addr", mem_req_addr, 64'h1000);
      wait_idle("seq_done");
      chk("seq_hs0_pc", hs_log[h0].pc, 64'h1000);
      chk("seq_hs0_instr", 64'(hs_log[h0].instr), 64'h00100073);
      chk("seq_hs1_pc", hs_log[h0+1].pc, 64'h1004);
      chk("seq_hs1_instr", 64'(hs_log[h0+1].instr), 64'h00500093);
      chk("seq_next_fetch", fetch_log[f0+1], 64'h1008);
      chk("seq_count", 64'(instr_count), 64'd2);

      // misaligned entry: only the high word of the first doubleword
      f0 = fetch_log.size(); h0 = hs_log.size();
      start_at(64'h2006);
      wait_idle("mis_done");
      chk("mis_first_fetch", fetch_log[f0], 64'h2000);
      chk("mis_hs0_pc", hs_log[h0].pc, 64'h2004);
      chk("mis_hs0_instr", 64'(hs_log[h0].instr), 64'h00000013);
      chk("mis_next_fetch", fetch_log[f0+1], 64'h2008);
      chk("mis_count", 64'(instr_count), 64'd4);

      // backpressure
      dec_ready = 1'b0;
      start_at(64'h1000);
      wait_for(0, "bp_dec_valid");
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 64'(dec_valid), 64'd1);
         chk("bp_pc", dec_pc, 64'h1000);
         chk("bp_instr", 64'(dec_instr), 64'h00100073);
         chk("bp_no_req", 64'(mem_req_valid), 64'd0);
         chk("bp_count", 64'(instr_count), 64'd4);
         @(posedge clk);
         #1;
      end
      dec_ready = 1'b1;
      wait_idle("bp_done");
      chk("bp_count_after", 64'(instr_count), 64'd6);

      // redirect while waiting for the response
      resp_lat = 4;
      f0 = fetch_log.size(); h0 = hs_log.size();
      start_at(64'h1000);
      wait_for(1, "rw_req");
      @(posedge clk);
      #1;
      chk("rw_in_wait", 64'(mem_req_valid), 64'd0);
      redirect_to(64'h3000);
      chk("rw_flush_no_req", 64'(mem_req_valid), 64'd0);
      wait_idle("rw_done");
      chk("rw_new_fetch", fetch_log[f0+1], 64'h3000);
      chk("rw_hs0_pc", hs_log[h0].pc, 64'h3000);
      chk("rw_hs0_instr", 64'(hs_log[h0].instr), 64'h00000093);
      chk("rw_count", 64'(instr_count), 64'd8);
      resp_lat = 2;

      // redirect while a request is not yet accepted
      auto_ready = 1'b0;
      start_at(64'h1000);
      wait_for(1, "rr_req");
      chk("rr_old_addr", mem_req_addr, 64'h1000);
      @(posedge clk);
      #1;
      redirect_to(64'h3001);
      chk("rr_still_req", 64'(mem_req_valid), 64'd1);
      chk("rr_new_addr", mem_req_addr, 64'h3000);
      auto_ready = 1'b1;
      wait_idle("rr_done");
      chk("rr_count", 64'(instr_count), 64'd10);

      // redirect together with a decoder handshake
      dec_ready = 1'b0;
      start_at(64'h1000);
      wait_for(0, "rd_dec_valid");
      dec_ready = 1'b1;
      redirect_to(64'h4002);
      chk("rd_count", 64'(instr_count), 64'd11);
      chk("rd_dec_off", 64'(dec_valid), 64'd0);
      chk("rd_req", 64'(mem_req_valid), 64'd1);
      chk("rd_addr", mem_req_addr, 64'h4000);
      wait_idle("rd_done");
      chk("rd_last_pc", hs_log[hs_log.size()-1].pc, 64'h4000);
      chk("rd_last_instr", 64'(hs_log[hs_log.size()-1].instr), 64'h00400013);
      chk("rd_count_after", 64'(instr_count), 64'd12);

      // halt on a zero low word, then restart
      h0 = hs_log.size();
      start_at(64'h5000);
      wait_idle("halt_done");
      chk("halt_no_dec", 64'(hs_log.size()), 64'(h0));
      chk("halt_busy_low", 64'(busy), 64'd0);
      chk("halt_total", 64'(halt_cnt), 64'd7);
      chk("halt_count", 64'(instr_count), 64'd12);
      start_at(64'h1000);
      wait_idle("restart_done");
      chk("restart_count", 64'(instr_count), 64'd14);
      chk("restart_halts", 64'(halt_cnt), 64'd8);

      // asynchronous reset while a fetch is outstanding
      resp_lat = 6;
      start_at(64'h1000);
      wait_for(1, "ar_req");
      @(posedge clk);
      #3;
      chk_en  = 1'b0;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      exp_dec.delete(); exp_fetch.delete();
      halt_pend = 1'b0; exp_count = 0; outst = 0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk_en  = 1'b1;
      resp_lat = 2;
      @(posedge clk);
      #1;
      start_at(64'h1000);
      wait_idle("post_reset_done");
      chk("post_reset_count", 64'(instr_count), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_decode_sequencer.md
Name: fetch_decode_sequencer

Overview:
- Sits between the instruction memory port and the instruction decoder.
- Issues 8-byte-aligned fetches and unpacks each 64-bit response into two 32-bit instructions (low word first).
- Presents instructions to the decoder one at a time with a valid/ready handshake, tracking the PC of each.
- Handles branch redirects (flushing stale data and in-flight fetches) and halts on an all-zero instruction word.

Parameters:
- ADDR_W, 64, width of PC and memory address.
- RESET_PC, 64'h0, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching at entry_pc; honoured only in IDLE.
- entry_pc  in  ADDR_W  start address; bits [1:0] ignored.
- mem_req_valid  out  1  fetch request valid.
- mem_req_addr  out  ADDR_W  fetch address, always {pc[ADDR_W-1:3],3'b000}.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  fetch data valid; one response per accepted request, in order.
- mem_resp_data  in  64  fetched doubleword; [31:0] at addr, [63:32] at addr+4.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored.
- dec_valid  out  1  instruction valid to decoder.
- dec_instr  out  32  instruction word.
- dec_pc  out  ADDR_W  PC of dec_instr.
- dec_ready  in  1  decoder accepts instruction.
- busy  out  1  state != IDLE.
- halted  out  1  one-cycle pulse on zero-instruction halt.
- instr_count  out  32  count of completed decoder handshakes.

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE, pc=RESET_PC, slot=0, buffer=0, instr_count=0.
  - All outputs 0, except dec_pc and mem_req_addr, which follow the pc register.
- All outputs are derived from registers only; there is no combinational input-to-output path.
- States: IDLE, REQ, WAIT, DRAIN, FLUSH.
- IDLE:
  - start=1 -> pc<=entry_pc with [1:0] cleared, state<=REQ.
  - redirect_valid, mem_resp_valid and dec_ready are ignored.
- REQ:
  - mem_req_valid=1.
  - mem_req_ready=1 -> state<=WAIT.
  - Address stays stable until accepted, except on redirect.
- WAIT:
  - mem_resp_valid=1 -> buffer<=mem_resp_data, slot<=pc[2], state<=DRAIN.
- DRAIN:
  - dec_valid=1 unless the selected word is 32'h0.
  - dec_instr = slot ? buffer[63:32] : buffer[31:0]; dec_pc=pc.
  - Handshake (dec_valid & dec_ready):
    - pc<=pc+4 and instr_count<=instr_count+1 (wraps at 2^32).
    - If slot==0: slot<=1 and stay in DRAIN (second word, no new fetch).
    - If slot==1: state<=REQ.
  - Selected word == 32'h0: dec_valid stays 0; next cycle state<=IDLE, halted=1 for one cycle, pc holds the address of the zero word.
- Zero-word word order: a zero in the low word halts before the high word is presented.
- Redirect (any state except IDLE), pc<=redirect_pc & ~3:
  - REQ without mem_req_ready: the request is withdrawn; state stays REQ; the new address appears the next cycle.
  - REQ with mem_req_ready in the same cycle: the old request is accepted; state<=FLUSH.
  - WAIT without mem_resp_valid: state<=FLUSH.
  - WAIT with mem_resp_valid in the same cycle: the data is discarded; state<=REQ.
  - DRAIN: state<=REQ and dec_valid=0 from the next cycle. If dec_ready=1 in the same cycle, the handshake still counts (instr_count increments), but pc takes the redirect target, not pc+4.
  - FLUSH: only pc updates; state remains FLUSH.
  - Redirect has priority over halt detection in the same cycle.
- FLUSH:
  - Waits for the stale mem_resp_valid, discards the data, then state<=REQ.
- Exactly one outstanding fetch at any time.
- mem_resp_valid in IDLE, REQ or DRAIN is ignored.
- start outside IDLE is ignored.
- reset_n asserted mid-operation aborts immediately to reset values. Any in-flight memory response is the memory model's responsibility to drop.

Test Plan:
- Sequential fetch:
  - Stimulus: start, entry_pc=0x1000; resp 0x00500093_00100073 with dec_ready=1.
  - Response: mem_req_addr=0x1000; dec pairs (0x1000, 0x00100073) then (0x1004, 0x00500093); next mem_req_addr=0x1008; instr_count=2.
- Misaligned entry:
  - Stimulus: entry_pc=0x2004.
  - Response: mem_req_addr=0x2000; only the high word is presented, with dec_pc=0x2004; next fetch 0x2008.
- Backpressure:
  - Stimulus: dec_ready=0 for 5 cycles.
  - Response: dec_valid/dec_instr/dec_pc stable; no new mem_req_valid; instr_count unchanged.
- Redirect in WAIT:
  - Stimulus: redirect_pc=0x3000 before the response arrives.
  - Response: the stale response is discarded (FLUSH); next mem_req_addr=0x3000; no stale instruction presented.
- Redirect with simultaneous handshake in DRAIN:
  - Stimulus: redirect_pc=0x4002 together with dec_ready=1.
  - Response: instr_count increments; next mem_req_addr=0x4000; dec_pc of the first new instruction is 0x4000.
- Halt:
  - Stimulus: resp low word 0x00000000.
  - Response: dec_valid never asserted; halted pulses once; busy=0; a subsequent start restarts correctly.
  - Also: assert reset_n=0 in WAIT -> all outputs return to reset values asynchronously.
